rot_decoder: RTL and testbench
==============================

ROT_DECODER -- requirements
Module: rot_decoder

Interface
REQ-001 Parameter DIV, default 12000, sets the sample-tick period in clk cycles (1 kHz at 12 MHz); legal range is 2 or more.
REQ-002 Parameter STABLE, default 3, sets the number of consecutive equal samples needed to accept a new input level; legal range is 1 to 15.
REQ-003 Parameter WIDTH, default 8, sets the width of the position counter.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port enc_a, input, 1 bit: encoder phase A, asynchronous to clk.
REQ-007 Port enc_b, input, 1 bit: encoder phase B, asynchronous to clk.
REQ-008 Port step, output, 1 bit: one-cycle pulse for each legal quadrature transition.
REQ-009 Port dir, output, 1 bit: direction of the last step (1 = CW, 0 = CCW); holds between steps.
REQ-010 Port pos, output, WIDTH bits: signed position count, wraps modulo 2^WIDTH.
REQ-011 Port err, output, 1 bit: one-cycle pulse when both phases change in the same accepted update.

Function
REQ-012 enc_a and enc_b each pass through a 2-flop synchronizer before any other use.
REQ-013 A tick counter counts 0..DIV-1 and wraps; tick asserts for exactly one cycle when the count equals DIV-1.
REQ-014 Samples are taken only in tick cycles; the sample is the synchronized {b,a} pair.
REQ-015 Debounce on a tick: if sample equals cand, cnt increments, saturating at STABLE; otherwise cand <= sample and cnt <= 1.
REQ-016 Accept: when cnt reaches STABLE (including STABLE = 1 on first sample) and cand != deb, deb <= cand in that same tick cycle.
REQ-017 Decode happens in the cycle after deb changes, comparing the new deb against prev (the value held before the update).
- REQ-017a CW sequence {b,a}: 00->01->11->10->00.
- REQ-017b CCW is the reverse sequence.
REQ-018 On a CW transition: step=1, dir<=1, pos<=pos+1.
REQ-019 On a CCW transition: step=1, dir<=0, pos<=pos-1.
REQ-020 pos wraps at both ends: all-ones+1 gives 0; 0-1 gives all-ones.
REQ-021 When prev^deb == 11: err=1, step=0, and pos and dir are unchanged.
REQ-022 Outputs are registered, so step, err and pos update one cycle after deb changes.
REQ-023 Worst-case latency from a stable input change to step is 2 (sync) + STABLE*DIV + 2 cycles.
REQ-024 A glitch shorter than STABLE consecutive ticks never changes deb.
REQ-025 A level that returns to deb before acceptance produces no output.
REQ-026 Init state machine: LOAD -> RUN.
- REQ-026a In LOAD, the first accepted level is copied into deb and prev with no step and no err, then the machine moves to RUN.
- REQ-026b In LOAD, acceptance happens even if cand equals the reset value of deb.
REQ-027 step and err are never high in the same cycle.

Reset
REQ-028 While rst_n=0 at a clk edge, the following clear to 0: tick counter, cnt, cand, deb, prev, step, err, dir and pos; the synchronizer flops also clear to 0.
REQ-029 Reset puts the init state machine in LOAD.
REQ-030 Reset mid-debounce or mid-sequence discards all pending state, and no output pulse is generated because of the reset.

Verification
(all scenarios use DIV=4, STABLE=3, WIDTH=8)
REQ-031 Hold {b,a}=11 through reset release -> no step and no err; deb=11 after 2+3*4 cycles; pos=0.
REQ-032 Drive the CW sequence 00,01,11,10,00, each level held 20 cycles -> four step pulses, dir=1, pos=4.
REQ-033 Drive the CCW sequence from pos=0 for 4 transitions -> pos=0xFC, dir=0.
REQ-034 From deb=00, apply a 01 glitch lasting 6 cycles, then return to 00 -> no step, pos unchanged.
REQ-035 From deb=00, switch directly to 11 and hold 20 cycles -> one err pulse, no step, pos unchanged; the next transition 11->10 -> a CW step.
REQ-036 Assert rst_n=0 for 1 cycle in the middle of the debounce of a new level -> all outputs 0, state machine in LOAD; the next stable level loads without step.

Source files
------------

// File: rtl/rot_decoder.sv
// rtl/rot_decoder.sv - debounced quadrature rotary encoder decoder with signed position count
module rot_decoder #(
    parameter int DIV    = 12000,
    parameter int STABLE = 3,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] pos,
    output logic             err
);

    localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           a_meta, a_sync, b_meta, b_sync;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [1:0]     sample;
    logic [1:0]     cand, cand_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [1:0]     deb, prev;
    logic           accept;
    logic           load_accept;
    logic [1:0]     diff;
    logic           chg;
    logic           cw;
    logic           move;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= enc_a;
            a_sync <= a_meta;
            b_meta <= enc_b;
            b_sync <= b_meta;
        end
    end

    assign tick   = (tick_cnt == TW'(DIV - 1));
    assign sample = {b_sync, a_sync};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Debounce candidate tracking; acceptance looks at the post-update count so STABLE=1 accepts on first sample.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (tick) begin
            if (sample == cand) begin
                cnt_nxt = (cnt == 4'(STABLE)) ? cnt : cnt + 4'd1;
            end else begin
                cand_nxt = sample;
                cnt_nxt  = 4'd1;
            end
        end
    end

    assign accept      = tick && (cnt_nxt == 4'(STABLE)) && ((state == LOAD) || (cand_nxt != deb));
    assign load_accept = accept && (state == LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            cand  <= 2'b00;
            cnt   <= 4'd0;
            deb   <= 2'b00;
            prev  <= 2'b00;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                deb <= cand_nxt;
            end
            // prev trails deb by one cycle, so a mismatch marks exactly the cycle after an update
            prev <= load_accept ? cand_nxt : deb;
        end
    end

    assign diff = prev ^ deb;
    assign chg  = (state == RUN) && (deb != prev);
    assign cw   = ((prev == 2'b00) && (deb == 2'b01)) ||
                  ((prev == 2'b01) && (deb == 2'b11)) ||
                  ((prev == 2'b11) && (deb == 2'b10)) ||
                  ((prev == 2'b10) && (deb == 2'b00));
    assign move = chg && (diff != 2'b11);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= 1'b0;
            err  <= 1'b0;
            dir  <= 1'b0;
            pos  <= '0;
        end else begin
            step <= move;
            err  <= chg && (diff == 2'b11);
            if (move) begin
                dir <= cw;
                pos <= cw ? pos + WIDTH'(1) : pos - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rot_decoder.sv
// tb/tb_rot_decoder.sv - scoreboard bench for rot_decoder with directed encoder sequences
module tb_rot_decoder;

    logic       clk;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic       step;
    logic       dir;
    logic [7:0] pos;
    logic       err;

    typedef struct {
        logic       is_err;
        logic       dir;
        logic [7:0] pos;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] m_deb;
    logic [7:0] m_pos;
    logic       m_dir;

    rot_decoder #(.DIV(4), .STABLE(3), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .step  (step),
        .dir   (dir),
        .pos   (pos),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && (step || err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got step=%0b err=%0b dir=%0b pos=%02h, expected no event",
                         step, err, dir, pos);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((err !== e.is_err) || (step !== !e.is_err) || (dir !== e.dir) || (pos !== e.pos)) begin
                    errors++;
                    $display("FAIL event: got step=%0b err=%0b dir=%0b pos=%02h, expected step=%0b err=%0b dir=%0b pos=%02h",
                             step, err, dir, pos, !e.is_err, e.is_err, e.dir, e.pos);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_enc(input logic [1:0] lvl);
        enc_b = lvl[1];
        enc_a = lvl[0];
    endtask

    task automatic drive_level(input logic [1:0] lvl, input int hold);
        ev_t        e;
        logic [1:0] d;
        d = m_deb ^ lvl;
        if (d == 2'b11) begin
            e.is_err = 1'b1;
            e.dir    = m_dir;
            e.pos    = m_pos;
            exp_q.push_back(e);
        end else if (d != 2'b00) begin
            m_dir = ((m_deb == 2'b00) && (lvl == 2'b01)) || ((m_deb == 2'b01) && (lvl == 2'b11)) ||
                    ((m_deb == 2'b11) && (lvl == 2'b10)) || ((m_deb == 2'b10) && (lvl == 2'b00));
            m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
            e.is_err = 1'b0;
            e.dir    = m_dir;
            e.pos    = m_pos;
            exp_q.push_back(e);
        end
        m_deb = lvl;
        set_enc(lvl);
        cycles(hold);
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d outstanding events, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        check_val({name, "_pos"}, pos, m_pos);
        check_val({name, "_dir"}, {7'd0, dir}, {7'd0, m_dir});
    endtask

    task automatic do_reset(input logic [1:0] lvl, input int len, input bit check_zero);
        set_enc(lvl);
        rst_n = 1'b0;
        cycles(len);
        if (check_zero) begin
            check_val("rst_step", {7'd0, step}, 8'd0);
            check_val("rst_err", {7'd0, err}, 8'd0);
            check_val("rst_dir", {7'd0, dir}, 8'd0);
            check_val("rst_pos", pos, 8'd0);
        end
        rst_n = 1'b1;
        m_deb = lvl;
        m_pos = 8'd0;
        m_dir = 1'b0;
        cycles(30);
    endtask

    initial begin
        rst_n = 1'b0;
        set_enc(2'b11);
        m_deb = 2'b11;
        m_pos = 8'd0;
        m_dir = 1'b0;
        cycles(1);

        // reset state, level 11 held through release loads silently
        do_reset(2'b11, 3, 1'b1);
        check_idle("load11");
        drive_level(2'b10, 20);
        check_idle("after_load11");

        // CW sequence
        do_reset(2'b00, 3, 1'b0);
        drive_level(2'b01, 20);
        drive_level(2'b11, 20);
        drive_level(2'b10, 20);
        drive_level(2'b00, 20);
        check_idle("cw");

        // CCW sequence from zero, wrapping below zero
        do_reset(2'b00, 3, 1'b0);
        drive_level(2'b10, 20);
        drive_level(2'b11, 20);
        drive_level(2'b01, 20);
        drive_level(2'b00, 20);
        check_idle("ccw");

        // short glitch
        set_enc(2'b01);
        cycles(6);
        set_enc(2'b00);
        cycles(30);
        check_idle("glitch");

        // double-phase change then a legal CW move
        drive_level(2'b11, 20);
        check_idle("err");
        drive_level(2'b10, 20);
        check_idle("after_err");

        // reset in the middle of debouncing a new level
        set_enc(2'b00);
        cycles(8);
        do_reset(2'b00, 1, 1'b1);
        check_idle("mid_reset");
        drive_level(2'b01, 20);
        check_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
